// File: rtl/softmax_norm.sv
// Softmax normalisation stage: buffers N exponentials, sums them, then emits
// e_i/sum as Q16.16 via a bit-serial restoring divider (W+FRAC cycles/word).
//
//   state | meaning
//   LOAD  | accepting input words, accumulating sum
//   DIV   | one quotient bit per cycle for element rd_idx
//   OUT   | holding quotient on out_data until handshake
module softmax_norm #(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = W + $clog2(N);
  localparam int DIV_W = W + FRAC;
  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [DIV_W-1:0] Q_ONE = DIV_W'(1) << FRAC;

  typedef enum logic [1:0] {LOAD, DIV, OUT} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       mem [N];
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   rem;
  logic [DIV_W-1:0]   quot;
  logic [CNT_W-1:0]   bit_cnt;
  logic [W-1:0]       out_word;

  logic               in_hs, out_hs;
  logic               last_in, last_out, last_bit;
  logic [DIV_W-1:0]   dividend;
  logic [ACC_W:0]     trial;
  logic               sub_ok;
  logic [ACC_W-1:0]   rem_nxt;
  logic [DIV_W-1:0]   quot_nxt;
  logic [W-1:0]       result;

  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign last_in  = (wr_idx == IDX_W'(N - 1));
  assign last_out = (rd_idx == IDX_W'(N - 1));
  assign last_bit = (bit_cnt == '0);

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    dividend = {mem[rd_idx], {FRAC{1'b0}}};
    trial    = {rem, dividend[bit_cnt]};
    sub_ok   = (trial >= {1'b0, sum});
    rem_nxt  = sub_ok ? ACC_W'(trial - {1'b0, sum}) : trial[ACC_W-1:0];
    quot_nxt = {quot[DIV_W-2:0], sub_ok};
    if (sum == '0)
      result = '0;
    else if (quot_nxt > Q_ONE)
      result = W'(Q_ONE);
    else
      result = W'(quot_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_hs && last_in) state_nxt = DIV;
      DIV:     if (last_bit) state_nxt = OUT;
      OUT:     if (out_hs) state_nxt = last_out ? LOAD : DIV;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == OUT);
    out_data  = out_valid ? out_word : '0;
    out_last  = out_valid && last_out;
    busy      = !((state == LOAD) && (wr_idx == '0));
  end

  // Buffer has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (in_hs)
      mem[wr_idx] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      sum      <= '0;
      rem      <= '0;
      quot     <= '0;
      bit_cnt  <= '0;
      out_word <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            sum <= sum + ACC_W'(in_data);
            if (last_in) begin
              wr_idx  <= '0;
              rd_idx  <= '0;
              rem     <= '0;
              quot    <= '0;
              bit_cnt <= CNT_W'(DIV_W - 1);
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        DIV: begin
          rem     <= rem_nxt;
          quot    <= quot_nxt;
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (last_bit)
            out_word <= result;
        end
        OUT: begin
          if (out_hs) begin
            if (last_out) begin
              sum    <= '0;
              rd_idx <= '0;
            end else begin
              rd_idx  <= rd_idx + IDX_W'(1);
              rem     <= '0;
              quot    <= '0;
              bit_cnt <= CNT_W'(DIV_W - 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Self-checking bench for softmax_norm (N=4): directed and random vectors
// against an arithmetic reference, plus latency, backpressure and reset checks.
module tb_softmax_norm;

  localparam int N   = 4;
  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int     vectors = 0;
  int     errs    = 0;
  longint acc_t;
  longint hs_t;

  always #(PER/2) clk = ~clk;

  softmax_norm #(.N(N), .W(32), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // y = floor(e * 2^16 / sum), zero when sum is zero, capped at 1.0
  function automatic logic [31:0] model(input logic [31:0] e, input logic [63:0] s);
    logic [63:0] q;
    if (s == 0) return 32'h0;
    q = ({32'h0, e} << 16) / s;
    if (q > 64'h10000) return 32'h0001_0000;
    return q[31:0];
  endfunction

  task automatic push(input logic [31:0] w);
    int t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input longint ref_t);
    int t = 0;
    while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_latency"}, 64'($time - 1 - ref_t), 64'(48 * PER));
  endtask

  task automatic pop(input string tag, input logic [31:0] exp, input logic exp_last,
                     input longint ref_t);
    wait_valid(tag, ref_t);
    chk({tag, "_data"}, {32'b0, out_data}, {32'b0, exp});
    chk({tag, "_last"}, {63'b0, out_last}, {63'b0, exp_last});
    @(posedge clk);
    hs_t = $time;
    #1;
  endtask

  task automatic run_vector(input string tag, input logic [31:0] v [N]);
    logic [63:0] s = 0;
    for (int i = 0; i < N; i++) begin
      push(v[i]);
      s += {32'b0, v[i]};
    end
    chk({tag, "_in_ready_div"}, {63'b0, in_ready}, 64'd0);
    hs_t = acc_t;
    for (int i = 0; i < N; i++)
      pop($sformatf("%s_%0d", tag, i), model(v[i], s), (i == N - 1), hs_t);
  endtask

  logic [31:0] vec [N];
  logic [63:0] bsum;
  logic [31:0] hold_d;
  logic        hold_l;
  logic        stable;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data",  {32'b0, out_data},  64'd0);
    chk("rst_out_last",  {63'b0, out_last},  64'd0);
    chk("rst_busy",      {63'b0, busy},      64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push(32'h0001_0000);
    chk("busy_after_first", {63'b0, busy}, 64'd1);
    push(32'h0001_0000); push(32'h0001_0000); push(32'h0001_0000);
    hs_t = acc_t;
    for (int i = 0; i < N; i++) begin
      pop($sformatf("equal_%0d", i), model(32'h0001_0000, 64'h40000), (i == N - 1), hs_t);
      chk("equal_const", {32'b0, model(32'h0001_0000, 64'h40000)}, 64'h4000);
    end
    chk("idle_busy", {63'b0, busy}, 64'd0);

    vec = '{32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0};
    run_vector("mixed", vec);
    vec = '{32'h0002_B7E1, 32'h0, 32'h0, 32'h0};
    run_vector("single", vec);
    vec = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_vector("zero", vec);
    vec = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0};
    run_vector("third", vec);

    // backpressure: hold out_ready low for 20 cycles on the first word
    out_ready = 1'b0;
    vec = '{32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0};
    bsum = 64'h40000;
    for (int i = 0; i < N; i++) push(vec[i]);
    wait_valid("bp0", acc_t);
    hold_d = out_data;
    hold_l = out_last;
    chk("bp0_data", {32'b0, hold_d}, {32'b0, model(vec[0], bsum)});
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== hold_d || out_last !== hold_l || in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", {63'b0, stable}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    hs_t = $time;
    #1;
    chk("bp_single_hs", {63'b0, out_valid}, 64'd0);
    for (int i = 1; i < N; i++)
      pop($sformatf("bp_%0d", i), model(vec[i], bsum), (i == N - 1), hs_t);

    // reset in the middle of a division
    for (int i = 0; i < N; i++) push($urandom);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("mid_rst_busy",      {63'b0, busy},      64'd0);
    chk("mid_rst_out_data",  {32'b0, out_data},  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    vec = '{32'h0000_8000, 32'h0003_0000, 32'h0001_2345, 32'h0000_0001};
    run_vector("post_rst", vec);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        vec[i] = (r < 3) ? $urandom : 32'($urandom_range(0, 32'h0004_0000));
      run_vector($sformatf("rand%0d", r), vec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
